// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StDone
   } state_e;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
   localparam int unsigned DEFAULT_DEPTH     = 64;

   localparam logic REQ_MEM = 1'b0;
   localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between requesters (MEM stage, debug/DMA), the arbiter and the data memory.
interface dmem_arbiter_if #(
   parameter int unsigned IDX_W = 6
);
   logic             m_req;
   logic             m_wr;
   logic [31:0]      m_addr;
   logic [31:0]      m_wdata;
   logic [31:0]      m_rdata;
   logic             m_ready;
   logic             freeze;

   logic             d_req;
   logic             d_wr;
   logic [31:0]      d_addr;
   logic [31:0]      d_wdata;
   logic [31:0]      d_rdata;
   logic             d_ready;

   logic             mem_en;
   logic             mem_we;
   logic [IDX_W-1:0] mem_idx;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   logic             err;

   // Arbiter side.
   modport slave (
      input  m_req, m_wr, m_addr, m_wdata, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output m_rdata, m_ready, freeze, d_rdata, d_ready, mem_en, mem_we, mem_idx, mem_wdata,
             err
   );

   // Requester / memory side.
   modport master (
      output m_req, m_wr, m_addr, m_wdata, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  m_rdata, m_ready, freeze, d_rdata, d_ready, mem_en, mem_we, mem_idx, mem_wdata,
             err
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_i == REQ_MEM) ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage vs debug port, fixed LAT-cycle access, byte-to-word indexing.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned IDX_W     = 6,
   parameter int unsigned LAT       = 2
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   localparam int unsigned    CntW    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(LAT - 1);

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic             last_q;
   logic             gnt_q;
   logic             wr_q;
   logic             oor_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic             mem_en_q;
   logic             mem_we_q;
   logic             m_ready_q;
   logic             d_ready_q;
   logic [31:0]      m_rdata_q;
   logic [31:0]      d_rdata_q;
   logic             err_q;

   logic [1:0]       req;
   logic [1:0]       gnt;
   logic             sel_wr;
   logic [31:0]      sel_addr;
   logic [31:0]      sel_wdata;
   logic [IDX_W-1:0] idx_d;
   logic             oor_d;
   logic [31:0]      cap_data;

   assign req = {bus.d_req, bus.m_req};

   rr_arbiter2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (gnt)
   );

   assign sel_wr    = gnt[1] ? bus.d_wr    : bus.m_wr;
   assign sel_addr  = gnt[1] ? bus.d_addr  : bus.m_addr;
   assign sel_wdata = gnt[1] ? bus.d_wdata : bus.m_wdata;
   assign idx_d     = IDX_W'((sel_addr - BASE_ADDR) >> 2);

`ifdef DMEM_RANGE_CHECK_EN
   // 33-bit compare so BASE_ADDR + 4*DEPTH cannot wrap.
   assign oor_d = ({1'b0, sel_addr} < {1'b0, BASE_ADDR}) ||
                  ({1'b0, sel_addr} >= ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
`else
   assign oor_d = 1'b0;
`endif

   // Writes and rejected accesses return zero load data.
   assign cap_data = (wr_q || oor_q) ? 32'h0 : bus.mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_q    <= REQ_DBG;
         gnt_q     <= REQ_MEM;
         wr_q      <= 1'b0;
         oor_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         m_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         m_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         m_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         err_q     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (|req) begin
                  gnt_q    <= gnt[1];
                  last_q   <= gnt[1];
                  wr_q     <= sel_wr;
                  idx_q    <= idx_d;
                  wdata_q  <= sel_wdata;
                  oor_q    <= oor_d;
                  cnt_q    <= '0;
                  mem_en_q <= ~oor_d;
                  mem_we_q <= sel_wr & ~oor_d;
                  state_q  <= StAccess;
               end
            end
            StAccess: begin
               if (cnt_q == CntLast) begin
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  err_q    <= oor_q;
                  if (gnt_q == REQ_DBG) begin
                     d_rdata_q <= cap_data;
                     d_ready_q <= 1'b1;
                  end else begin
                     m_rdata_q <= cap_data;
                     m_ready_q <= 1'b1;
                  end
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_idx   = idx_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.m_ready   = m_ready_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.m_rdata   = m_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.freeze    = bus.m_req & ~m_ready_q;

`ifdef DMEM_RANGE_CHECK_EN
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (LAT=2, BASE_ADDR=1024, DEPTH=64) with a behavioural memory.
module tb_dmem_arbiter;

   logic clk;
   logic rst;
   logic mem_init;
   int   checks;
   int   errors;

   logic [31:0] mem [64];

   dmem_arbiter_if #(.IDX_W(6)) bus ();

   dmem_arbiter #(
      .BASE_ADDR (32'd1024),
      .DEPTH     (64),
      .IDX_W     (6),
      .LAT       (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the clock edge while enabled.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_idx] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = mem[bus.mem_idx];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Single debug read from idle; checks the whole transaction.
   task automatic dbg_read(input string tag, input logic [31:0] addr, input logic exp_en,
                           input logic [5:0] exp_idx, input logic exp_err,
                           input logic [31:0] exp_rdata);
      tick();
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = addr;
      smp();
      chk({tag, " c0 d_ready"}, bus.d_ready, 1'b0);
      for (int c = 1; c <= 2; c++) begin
         tick(); smp();
         chk({tag, " access mem_en"}, bus.mem_en, exp_en);
         chk({tag, " access mem_we"}, bus.mem_we, 1'b0);
         if (exp_en) chk({tag, " access mem_idx"}, bus.mem_idx, exp_idx);
      end
      tick(); smp();
      chk({tag, " c3 d_ready"}, bus.d_ready, 1'b1);
      chk({tag, " c3 err"}, bus.err, exp_err);
      chk({tag, " c3 d_rdata"}, bus.d_rdata, exp_rdata);
      tick();
      bus.d_req = 1'b0;
      smp();
      chk({tag, " c4 d_ready"}, bus.d_ready, 1'b0);
      chk({tag, " c4 err"}, bus.err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      clk = 1'b0; rst = 1'b0; mem_init = 1'b1;
      bus.m_req = 1'b0; bus.m_wr = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
      bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      // Reset values; freeze stays combinational during reset.
      #2;
      chk("rst mem_en", bus.mem_en, 1'b0);
      chk("rst mem_we", bus.mem_we, 1'b0);
      chk("rst m_ready", bus.m_ready, 1'b0);
      chk("rst d_ready", bus.d_ready, 1'b0);
      chk("rst err", bus.err, 1'b0);
      chk("rst m_rdata", bus.m_rdata, 32'h0);
      chk("rst mem_idx", bus.mem_idx, 32'h0);
      chk("rst freeze0", bus.freeze, 1'b0);
      bus.m_req = 1'b1;
      #1;
      chk("rst freeze1", bus.freeze, 1'b1);
      bus.m_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      rst = 1'b1;

      // MEM write 1028 <- DEADBEEF.
      tick();
      bus.m_req = 1'b1; bus.m_wr = 1'b1; bus.m_addr = 32'd1028; bus.m_wdata = 32'hDEADBEEF;
      smp();
      chk("wr c0 freeze", bus.freeze, 1'b1);
      chk("wr c0 mem_en", bus.mem_en, 1'b0);
      for (int c = 1; c <= 2; c++) begin
         tick(); smp();
         chk("wr access mem_en", bus.mem_en, 1'b1);
         chk("wr access mem_we", bus.mem_we, 1'b1);
         chk("wr access mem_idx", bus.mem_idx, 32'd1);
         chk("wr access mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
         chk("wr access freeze", bus.freeze, 1'b1);
         chk("wr access m_ready", bus.m_ready, 1'b0);
      end
      tick(); smp();
      chk("wr c3 m_ready", bus.m_ready, 1'b1);
      chk("wr c3 freeze", bus.freeze, 1'b0);
      chk("wr c3 mem_en", bus.mem_en, 1'b0);
      chk("wr c3 m_rdata", bus.m_rdata, 32'h0);
      tick();
      bus.m_req = 1'b0;
      smp();
      chk("wr c4 m_ready", bus.m_ready, 1'b0);
      chk("wr memory word1", mem[1], 32'hDEADBEEF);

      // MEM read back 1028.
      tick();
      bus.m_req = 1'b1; bus.m_wr = 1'b0;
      smp();
      tick(); smp();
      chk("rd c1 mem_en", bus.mem_en, 1'b1);
      chk("rd c1 mem_we", bus.mem_we, 1'b0);
      chk("rd c1 mem_idx", bus.mem_idx, 32'd1);
      tick(); smp();
      tick(); smp();
      chk("rd c3 m_ready", bus.m_ready, 1'b1);
      chk("rd c3 m_rdata", bus.m_rdata, 32'hDEADBEEF);
      tick();
      bus.m_req = 1'b0;
      smp();

      // Tie from reset: MEM first, then debug, then MEM again (m_req held throughout).
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = 32'd1028;
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'd1276;
      smp();
      chk("tie c0 freeze", bus.freeze, 1'b1);
      tick(); smp();
      chk("tie c1 mem_idx", bus.mem_idx, 32'd1);
      tick(); smp();
      tick(); smp();
      chk("tie c3 m_ready", bus.m_ready, 1'b1);
      chk("tie c3 d_ready", bus.d_ready, 1'b0);
      chk("tie c3 m_rdata", bus.m_rdata, 32'hDEADBEEF);
      tick(); smp();
      chk("tie c4 m_ready", bus.m_ready, 1'b0);
      chk("tie c4 freeze", bus.freeze, 1'b1);
      chk("tie c4 mem_en", bus.mem_en, 1'b0);
      tick(); smp();
      chk("tie c5 mem_en", bus.mem_en, 1'b1);
      chk("tie c5 mem_idx", bus.mem_idx, 32'd63);
      tick(); smp();
      tick(); smp();
      chk("tie c7 d_ready", bus.d_ready, 1'b1);
      chk("tie c7 m_ready", bus.m_ready, 1'b0);
      chk("tie c7 d_rdata", bus.d_rdata, 32'h1000_003F);
      tick();
      bus.d_req = 1'b0;
      smp();
      chk("tie c8 freeze", bus.freeze, 1'b1);
      tick(); smp();
      chk("tie c9 mem_idx", bus.mem_idx, 32'd1);
      tick(); smp();
      tick(); smp();
      chk("tie c11 m_ready", bus.m_ready, 1'b1);
      chk("tie c11 d_rdata held", bus.d_rdata, 32'h1000_003F);
      tick();
      bus.m_req = 1'b0;
      smp();

      // Range boundaries on the debug port.
`ifdef DMEM_RANGE_CHECK_EN
      dbg_read("dbg 1280", 32'd1280, 1'b0, 6'd0, 1'b1, 32'h0);
      dbg_read("dbg 1020", 32'd1020, 1'b0, 6'd0, 1'b1, 32'h0);
`else
      dbg_read("dbg 1280", 32'd1280, 1'b1, 6'd0, 1'b0, 32'h1000_0000);
      dbg_read("dbg 1020", 32'd1020, 1'b1, 6'd63, 1'b0, 32'h1000_003F);
`endif
      dbg_read("dbg 1276", 32'd1276, 1'b1, 6'd63, 1'b0, 32'h1000_003F);

      // Reset during ACCESS cycle 1, held m_req restarts after release.
      tick();
      bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = 32'd1028;
      smp();
      tick(); smp();
      chk("rstmid c1 mem_en", bus.mem_en, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("rstmid mem_en", bus.mem_en, 1'b0);
      chk("rstmid mem_we", bus.mem_we, 1'b0);
      chk("rstmid m_rdata", bus.m_rdata, 32'h0);
      tick(); smp();
      chk("rstmid held m_ready", bus.m_ready, 1'b0);
      chk("rstmid held mem_en", bus.mem_en, 1'b0);
      #1 rst = 1'b1;
      tick(); smp();
      chk("rstmid k+1 mem_en", bus.mem_en, 1'b1);
      chk("rstmid k+1 m_ready", bus.m_ready, 1'b0);
      tick(); smp();
      chk("rstmid k+2 m_ready", bus.m_ready, 1'b0);
      tick(); smp();
      chk("rstmid k+3 m_ready", bus.m_ready, 1'b1);
      chk("rstmid k+3 m_rdata", bus.m_rdata, 32'hDEADBEEF);
      tick();
      bus.m_req = 1'b0;
      smp();

      // m_req dropped in cycle 1: transaction still completes, no new grant afterwards.
      tick();
      bus.m_req = 1'b1; bus.m_wr = 1'b1; bus.m_addr = 32'd1032; bus.m_wdata = 32'h1234_5678;
      smp();
      tick();
      bus.m_req = 1'b0;
      smp();
      chk("drop c1 freeze", bus.freeze, 1'b0);
      chk("drop c1 mem_we", bus.mem_we, 1'b1);
      chk("drop c1 mem_idx", bus.mem_idx, 32'd2);
      tick(); smp();
      tick(); smp();
      chk("drop c3 m_ready", bus.m_ready, 1'b1);
      tick(); smp();
      chk("drop c4 m_ready", bus.m_ready, 1'b0);
      chk("drop c4 mem_en", bus.mem_en, 1'b0);
      tick(); smp();
      chk("drop c5 mem_en", bus.mem_en, 1'b0);
      chk("drop memory word2", mem[2], 32'h1234_5678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the pipeline MEM stage (requester 0) and a debug/DMA port (requester 1). Sequences each access over a fixed multi-cycle memory latency and translates byte addresses to word indices. Drives the pipeline freeze while a MEM-stage access is pending. Sits between the MEM stage and the data memory array.

Parameters:
BASE_ADDR, 1024, byte address of data memory word 0
DEPTH, 64, number of 32-bit words
IDX_W, 6, word-index width (log2 DEPTH)
LAT, 2, memory access cycles per transaction (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
m_req  in  1  MEM-stage request (MEM_R_EN | MEM_W_EN), level, held until m_ready
m_wr  in  1  MEM-stage write (1) / read (0)
m_addr  in  32  MEM-stage byte address (alu result)
m_wdata  in  32  MEM-stage store data (Value_Rm)
m_rdata  out  32  MEM-stage load data, valid with m_ready
m_ready  out  1  one-cycle completion pulse to MEM stage
freeze  out  1  pipeline stall = m_req & ~m_ready (combinational)
d_req, d_wr, d_addr[31:0], d_wdata[31:0]  in  debug port, same rules as m_*
d_rdata  out  32  debug load data
d_ready  out  1  debug completion pulse
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_idx  out  IDX_W  word index
mem_wdata  out  32  write data to memory
mem_rdata  in  32  read data from memory (valid by last ACCESS edge)
err  out  1  one-cycle pulse with ready: address out of range

Behaviour:
- Reset (rst=0, async): state IDLE, cycle counter 0, last_grant=1 (MEM wins first tie); all outputs 0 except freeze (combinational).
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: if any req, grant registered at clock edge: single requester wins; both -> round-robin, winner = requester not in last_grant; update last_grant. Latch wr, addr, wdata of winner.
- ACCESS: LAT cycles; mem_en=1, mem_we=latched wr, mem_idx/mem_wdata stable from latched values. On last ACCESS edge capture mem_rdata into granted rdata output; go DONE.
- DONE: granted ready=1 for exactly one cycle; rdata held until next grant to that requester; writes return rdata 0. Always -> IDLE; no arbitration in DONE.
- Latency: req in cycle 0 -> ready in cycle LAT+1; back-to-back grants every LAT+2 cycles.
- Requester must drop or change req in the cycle after ready; a still-asserted req in IDLE is a new transaction.
- Req deassert mid-transaction: transaction completes, ready still pulses.
- Index = (addr - BASE_ADDR) >> 2, truncated to IDX_W; addr[1:0] ignored.
- Reset mid-transaction: abort, mem_en/mem_we drop immediately, no ready.

Optional Feature:
DMEM_RANGE_CHECK_EN: defined -> addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH suppresses mem_en/mem_we for the whole ACCESS phase; rdata=0; err pulses with ready; timing unchanged. Undefined -> no check, index wraps modulo DEPTH, err tied 0.

Decomposition:
- dmem_pkg: state enum (IDLE/ACCESS/DONE), BASE_ADDR/DEPTH defaults, requester ID constants (REQ_MEM=0, REQ_DBG=1).
- Sub-module rr_arbiter2: two requests plus last_grant in, one-hot grant out, purely combinational.

Test Plan:
- MEM write addr 1028 data 0xDEADBEEF, LAT=2 -> mem_idx=1, mem_we high cycles 1-2, m_ready cycle 3, freeze high cycles 0-2.
- MEM read addr 1028 after write (memory model returns 0xDEADBEEF) -> m_rdata=0xDEADBEEF with m_ready, mem_we=0.
- Both req same cycle from reset -> MEM granted first, d_ready cycle LAT+1 after m_ready cycle (7), then next tie -> debug first.
- Debug read addr 1276 (idx 63) -> mem_idx=63; addr 1280 with DMEM_RANGE_CHECK_EN -> mem_en never high, err=1 with d_ready, d_rdata=0; without macro -> mem_idx=0.
- rst low during ACCESS cycle 1 -> mem_en=0 immediately, no m_ready; after release a held m_req restarts, m_ready LAT+1 cycles later.
- m_req dropped in cycle 1 -> m_ready still pulses cycle 3; FSM back in IDLE cycle 4 with no new grant.
